// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the 4-entry fully-associative cache controller.
package cache_ctrl_pkg;

  localparam int         NUM_ENTRIES = 4;
  localparam logic [1:0] AGE_MRU     = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    MEM_RD  = 3'd2,
    FILL    = 3'd3,
    MEM_WR  = 3'd4,
    RESPOND = 3'd5
  } state_t;

endpackage

// File: rtl/cache_lru_update.sv
// LRU age update: touched entry becomes most recent, entries newer than it age by one.
module cache_lru_update
  import cache_ctrl_pkg::*;
(
  input  logic [NUM_ENTRIES-1:0][1:0] i_age,
  input  logic [1:0]                  i_idx,
  output logic [NUM_ENTRIES-1:0][1:0] o_age
);

  always_comb begin
    for (int j = 0; j < NUM_ENTRIES; j++) begin
      if (j == int'(i_idx))
        o_age[j] = AGE_MRU;
      else if (i_age[j] > i_age[i_idx])
        o_age[j] = i_age[j] - 2'd1;
      else
        o_age[j] = i_age[j];
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Write-through, no-write-allocate cache sequencer with a 4-entry LRU entry array.
// state   | meaning
// IDLE    | waiting for cpu_req
// LOOKUP  | tag compare, counters, hit service
// MEM_RD  | read miss fetch from memory
// FILL    | victim replacement with fetched data
// MEM_WR  | write-through to memory
// RESPOND | one-cycle cpu_ack
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int d_width = 8,
  parameter int a_width = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [a_width-1:0] cpu_addr,
  input  logic [d_width-1:0] cpu_wdata,
  output logic [d_width-1:0] cpu_rdata,
  output logic               cpu_ack,
  output logic               busy,
  output logic               mem_req,
  output logic               mem_we,
  output logic [a_width-1:0] mem_addr,
  output logic [d_width-1:0] mem_wdata,
  input  logic [d_width-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [7:0]         hit_cnt,
  output logic [7:0]         miss_cnt
);

  state_t r_state, w_next;

  logic                          r_we;
  logic [a_width-1:0]            r_addr;
  logic [d_width-1:0]            r_wdata;
  logic [d_width-1:0]            r_mdata;
  logic [d_width-1:0]            r_rdata;
  logic [7:0]                    r_hit_cnt, r_miss_cnt;
  logic [NUM_ENTRIES-1:0]        r_valid;
  logic [a_width-1:0]            r_tag  [NUM_ENTRIES];
  logic [d_width-1:0]            r_data [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0][1:0]   r_age;

  logic                          w_hit;
  logic [1:0]                    w_hit_idx, w_vic_idx, w_touch_idx;
  logic [NUM_ENTRIES-1:0][1:0]   w_new_age;

  // descending scan so the lowest matching index wins
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (r_valid[i] && r_tag[i] == r_addr) begin
        w_hit     = 1'b1;
        w_hit_idx = 2'(i);
      end
    end
  end

  always_comb begin
    w_vic_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (r_age[i] == 2'd0) w_vic_idx = 2'(i);
    for (int i = NUM_ENTRIES-1; i >= 0; i--)
      if (!r_valid[i]) w_vic_idx = 2'(i);
  end

  assign w_touch_idx = (r_state == FILL) ? w_vic_idx : w_hit_idx;

  cache_lru_update u_lru (
    .i_age (r_age),
    .i_idx (w_touch_idx),
    .o_age (w_new_age)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cpu_req) w_next = LOOKUP;
      LOOKUP:  w_next = r_we ? MEM_WR : (w_hit ? RESPOND : MEM_RD);
      MEM_RD:  if (mem_ready) w_next = FILL;
      FILL:    w_next = RESPOND;
      MEM_WR:  if (mem_ready) w_next = RESPOND;
      RESPOND: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    cpu_ack   = (r_state == RESPOND);
    busy      = (r_state != IDLE);
    mem_req   = (r_state == MEM_RD) || (r_state == MEM_WR);
    mem_we    = (r_state == MEM_WR);
    mem_addr  = mem_req ? r_addr : '0;
    mem_wdata = mem_we ? r_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mdata    <= '0;
      r_rdata    <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_valid    <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
        r_age[i]  <= 2'(i);
      end
    end else begin
      case (r_state)
        IDLE: if (cpu_req) begin
          r_we    <= cpu_we;
          r_addr  <= cpu_addr;
          r_wdata <= cpu_wdata;
        end
        LOOKUP: begin
          if (w_hit) begin
            if (r_hit_cnt != 8'hFF) r_hit_cnt <= r_hit_cnt + 8'd1;
            r_age <= w_new_age;
            if (r_we) r_data[w_hit_idx] <= r_wdata;
            else      r_rdata <= r_data[w_hit_idx];
          end else if (r_miss_cnt != 8'hFF) begin
            r_miss_cnt <= r_miss_cnt + 8'd1;
          end
        end
        MEM_RD: if (mem_ready) r_mdata <= mem_rdata;
        FILL: begin
          r_valid[w_vic_idx] <= 1'b1;
          r_tag[w_vic_idx]   <= r_addr;
          r_data[w_vic_idx]  <= r_mdata;
          r_age              <= w_new_age;
          r_rdata            <= r_mdata;
        end
        default: ;
      endcase
    end
  end

  assign cpu_rdata = r_rdata;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench: directed vector table, hand sequences, random traffic vs. a cache model.
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic       cpu_ack, busy, mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       mem_ready = 1'b0;
  logic [7:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_ctrl #(.d_width(8), .a_width(8)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: entries plus a recency list (front = least recently used).
  bit         m_valid [4];
  logic [7:0] m_tag   [4];
  logic [7:0] m_data  [4];
  int         m_order [$];
  int         m_hits, m_misses;
  logic [7:0] m_rdata;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
    end
    m_order = '{0, 1, 2, 3};
    m_hits = 0; m_misses = 0; m_rdata = '0;
  endtask

  task automatic model_touch(input int k);
    for (int i = 0; i < m_order.size(); i++)
      if (m_order[i] == k) begin m_order.delete(i); break; end
    m_order.push_back(k);
  endtask

  function automatic int model_find(input logic [7:0] a);
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && m_tag[i] == a) return i;
    return -1;
  endfunction

  task automatic run_txn(input bit we, input logic [7:0] addr, wdata, memdata, input int delay,
                         output int lat, output int n_mem, output bit mwe,
                         output logic [7:0] maddr, output logic [7:0] mwdata,
                         output logic [7:0] rdata, output int rdy_at,
                         output bit ok, output bit busy_mid);
    int mcyc;
    n_mem = 0; mwe = 0; maddr = '0; mwdata = '0; rdata = '0;
    rdy_at = -1; lat = -1; ok = 0; busy_mid = 0; mcyc = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
    for (int n = 1; n <= 40; n++) begin
      mem_ready = 1'b0;
      mem_rdata = 8'($urandom);
      if (n == 1) busy_mid = busy;
      if (cpu_ack) begin lat = n; rdata = cpu_rdata; ok = 1; break; end
      if (mem_req) begin
        if (mcyc == 0) begin
          n_mem++; mwe = mem_we; maddr = mem_addr; mwdata = mem_wdata;
        end else begin
          check("mem_stable", int'(mem_we == mwe && mem_addr == maddr &&
                (!mwe || mem_wdata == mwdata)), 1);
        end
        if (mcyc >= delay) begin
          mem_ready = 1'b1; mem_rdata = memdata; rdy_at = n; mcyc = 0;
        end else begin
          mcyc++;
        end
      end else begin
        mcyc = 0;
        mem_ready = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  task automatic do_check(input string name, input bit we, input logic [7:0] addr, wdata, memdata,
                          input int delay, input bit exp_hit, input logic [7:0] exp_rdata,
                          input int exp_hits, input int exp_misses);
    int lat, n_mem, rdy_at;
    bit mwe, ok, busy_mid;
    logic [7:0] maddr, mwdata, rdata;
    run_txn(we, addr, wdata, memdata, delay, lat, n_mem, mwe, maddr, mwdata, rdata, rdy_at, ok, busy_mid);
    check({name, " ack_seen"}, int'(ok), 1);
    check({name, " busy"}, int'(busy_mid), 1);
    if (exp_hit && !we) begin
      check({name, " mem_count"}, n_mem, 0);
      check({name, " latency"}, lat, 2);
    end else begin
      check({name, " mem_count"}, n_mem, 1);
      check({name, " mem_we"}, int'(mwe), int'(we));
      check({name, " mem_addr"}, int'(maddr), int'(addr));
      if (we) check({name, " mem_wdata"}, int'(mwdata), int'(wdata));
      check({name, " latency"}, lat, rdy_at + (we ? 1 : 2));
    end
    check({name, " rdata"}, int'(rdata), int'(exp_rdata));
    check({name, " hit_cnt"}, int'(hit_cnt), exp_hits);
    check({name, " miss_cnt"}, int'(miss_cnt), exp_misses);
    @(negedge clk);
    check({name, " ack_one_cycle"}, int'(cpu_ack), 0);
    check({name, " idle_after"}, int'(busy), 0);
  endtask

  task automatic model_txn(input string name, input bit we, input logic [7:0] addr, wdata,
                           memdata, input int delay);
    int k, v;
    bit hit;
    k = model_find(addr);
    hit = (k >= 0);
    if (hit) m_hits = (m_hits < 255) ? m_hits + 1 : 255;
    else     m_misses = (m_misses < 255) ? m_misses + 1 : 255;
    if (!we && hit) begin
      m_rdata = m_data[k]; model_touch(k);
    end else if (!we) begin
      v = -1;
      for (int i = 3; i >= 0; i--) if (!m_valid[i]) v = i;
      if (v < 0) v = m_order[0];
      m_valid[v] = 1'b1; m_tag[v] = addr; m_data[v] = memdata;
      model_touch(v);
      m_rdata = memdata;
    end else if (hit) begin
      m_data[k] = wdata; model_touch(k);
    end
    do_check(name, we, addr, wdata, memdata, delay, hit, m_rdata, m_hits, m_misses);
  endtask

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] memdata;
    int         delay;
    bit         exp_hit;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int hits, misses, cnt, prev, first, waited;
    bit gap_ok, saw_ack;

    tbl[0]  = '{0, 8'h10, 8'h00, 8'hA5, 0, 0, 8'hA5};
    tbl[1]  = '{0, 8'h10, 8'h00, 8'h00, 0, 1, 8'hA5};
    tbl[2]  = '{0, 8'h20, 8'h00, 8'h22, 1, 0, 8'h22};
    tbl[3]  = '{0, 8'h30, 8'h00, 8'h33, 2, 0, 8'h33};
    tbl[4]  = '{0, 8'h40, 8'h00, 8'h44, 0, 0, 8'h44};
    tbl[5]  = '{0, 8'h10, 8'h00, 8'h00, 0, 1, 8'hA5};
    tbl[6]  = '{0, 8'h50, 8'h00, 8'h55, 3, 0, 8'h55};
    tbl[7]  = '{0, 8'h10, 8'h00, 8'h00, 0, 1, 8'hA5};
    tbl[8]  = '{0, 8'h20, 8'h00, 8'h2F, 0, 0, 8'h2F};
    tbl[9]  = '{0, 8'h30, 8'h00, 8'h3C, 1, 0, 8'h3C};
    tbl[10] = '{1, 8'h30, 8'h7E, 8'h00, 0, 1, 8'h3C};
    tbl[11] = '{0, 8'h30, 8'h00, 8'h00, 0, 1, 8'h7E};
    tbl[12] = '{1, 8'h99, 8'h5A, 8'h00, 2, 0, 8'h7E};
    tbl[13] = '{0, 8'h99, 8'h00, 8'h9C, 0, 0, 8'h9C};
    tbl[14] = '{0, 8'h50, 8'h00, 8'h5B, 1, 0, 8'h5B};

    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset ack", int'(cpu_ack), 0);
    check("reset mem_req", int'(mem_req), 0);
    check("reset rdata", int'(cpu_rdata), 0);
    check("reset counters", int'({hit_cnt, miss_cnt}), 0);
    rst = 1'b1;

    hits = 0; misses = 0;
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].exp_hit) hits++; else misses++;
      do_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].memdata,
               tbl[i].delay, tbl[i].exp_hit, tbl[i].exp_rdata, hits, misses);
    end

    // cpu_req held high: hits on 0x30 are accepted every third cycle
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
    cnt = 0; prev = -1; first = -1; gap_ok = 1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (cpu_ack) begin
        cnt++;
        if (prev >= 0 && n - prev != 3) gap_ok = 0;
        if (prev < 0) first = n;
        prev = n;
        check("b2b rdata", int'(cpu_rdata), 8'h7E);
      end
    end
    cpu_req = 1'b0;
    check("b2b ack_count", cnt, 3);
    check("b2b first_ack", first, 2);
    check("b2b spacing", int'(gap_ok), 1);
    repeat (4) @(negedge clk);
    check("b2b hit_cnt", int'(hit_cnt), hits + 3);

    // reset while a memory read is outstanding
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'hEE;
    @(negedge clk);
    cpu_req = 1'b0;
    waited = 0;
    while (!mem_req && waited < 10) begin @(negedge clk); waited++; end
    check("rst_mid mem_req_seen", int'(mem_req), 1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid busy", int'(busy), 0);
    check("rst_mid mem_req", int'(mem_req), 0);
    check("rst_mid ack", int'(cpu_ack), 0);
    check("rst_mid counters", int'({hit_cnt, miss_cnt}), 0);
    check("rst_mid rdata", int'(cpu_rdata), 0);
    rst = 1'b1;
    mem_ready = 1'b1;
    saw_ack = 0;
    repeat (4) begin @(negedge clk); if (cpu_ack || mem_req) saw_ack = 1; end
    mem_ready = 1'b0;
    check("rst_mid quiet", int'(saw_ack), 0);

    model_reset();
    model_txn("post_rst 0x30", 1'b0, 8'h30, 8'h00, 8'hC3, 0);
    model_txn("post_rst 0x10", 1'b0, 8'h10, 8'h00, 8'hC1, 1);

    for (int t = 0; t < 400; t++) begin
      logic [7:0] a;
      a = (t < 220) ? 8'(8'h10 * $urandom_range(1, 3)) : 8'(8'h10 * $urandom_range(1, 8));
      model_txn($sformatf("rnd%0d", t), ($urandom_range(0, 3) == 0), a,
                8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
